dcache_mem_stage: RTL and testbench
===================================

Name: dcache_mem_stage

Overview:
- Memory-stage data cache: direct-mapped, one 4-byte word per line, write-through, allocate on read miss, no allocate on write.
- Sits between EX and WB. Takes the load/store request, stalls the pipeline on misses and memory writes, and returns the four byte lanes plus the byte offset that WB uses to select and sign-extend load data.
- Byte lane convention (big-endian): the byte at address offset k is on cache_data_out[3-k]. A full word is {lane3, lane2, lane1, lane0}.

Parameters:
- INDEX_BITS, 5, number of line-index bits (2^INDEX_BITS lines). Tag width = 30 - INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  1  a load or store is present this cycle
- req_write  in  1  1 = store, 0 = load
- is_word  in  1  1 = word access, 0 = byte access
- addr  in  32  byte address (ALU result)
- store_data  in  32  store data; byte stores use [7:0]
- cache_data_out  out  4x8  lanes [0:3] toward WB
- byte_number  out  2  addr[1:0], passed through to WB
- stall  out  1  hold the pipeline (request must be held stable while stall=1)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_wdata  out  4x8  write lanes
- mem_byte_en  out  4  lane enables; bit i enables lane i
- mem_rdata  in  4x8  read lanes, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE; all valid bits cleared; mem_req=0, mem_we=0, mem_byte_en=0.
  - stall=0; cache_data_out all 0.
  - Reset during FILL or WRITE abandons the transaction immediately. Memory must tolerate mem_req dropping.
- Lookup: index=addr[INDEX_BITS+1:2], tag=addr[31:INDEX_BITS+2]. hit = valid[index] && tag match.
- States:
  - IDLE
  - FILL: read miss
  - WRITE: store in flight
- IDLE:
  - No req_valid: stall=0, cache_data_out=0.
  - Load hit: cache_data_out=line data combinationally, stall=0. Zero added latency.
  - Load miss: stall=1; go to FILL next edge.
  - Store (hit or miss): stall=1; go to WRITE next edge. On a hit, the line is updated at that same edge:
    - word store: all four lanes written;
    - byte store: only lane 3-addr[1:0] written, with store_data[7:0].
- FILL:
  - mem_req=1, mem_we=0, mem_byte_en=4'b1111.
  - stall=!mem_ack.
  - On mem_ack: cache_data_out=mem_rdata (forwarded). At that edge the line data, tag and valid are written, then go to IDLE.
- WRITE:
  - mem_req=1, mem_we=1, stall=!mem_ack.
  - Word store: mem_wdata={store_data[7:0], [15:8], [23:16], [31:24]} mapped to lanes 0..3; mem_byte_en=1111.
  - Byte store: store_data[7:0] on lane 3-addr[1:0] and 0 on the other lanes; mem_byte_en has only bit 3-addr[1:0] set.
  - cache_data_out=0.
  - On mem_ack, go to IDLE.
- mem_addr, mem_wdata and mem_byte_en are registered on entry to FILL/WRITE and held constant until mem_ack.
- If req_valid drops mid-transaction, the transaction still completes. A FILL still installs the line.
- mem_ack in IDLE is ignored.
- byte_number is always addr[1:0].
- Unaligned word addresses: addr[1:0] is ignored for word access.
- Back-to-back: the request after the ack edge is evaluated fresh in IDLE. A load following its own fill hits.

Test Plan:
1. Reset, then load word 0x0000_0040 with memory returning lanes {0x78,0x56,0x34,0x12} (lane0..3) after 3 cycles -> stall=1 for 3 cycles, deasserted in the ack cycle; cache_data_out forwarded in the ack cycle. A repeat load hits with stall=0 and the same data. No further mem_req.
2. Byte store 0xAB to 0x0000_0041 on the line loaded in test 1 -> mem_byte_en=0100, lane2=0xAB. A following load word returns lane2=0xAB, other lanes unchanged, stall=0.
3. Word store 0xDEADBEEF to 0x0000_0080 (miss) -> one write with lanes {0xEF,0xBE,0xAD,0xDE}, byte_en=1111. A following load to 0x80 misses and issues a FILL (no allocate on write).
4. Conflict: fill 0x0000_0040, then load 0x0000_00C0 (INDEX_BITS=5, different tag, same index 0x10 only if the index matches) -> use 0x0000_0040 and 0x0000_0040 + 128 = 0x0000_00C0. The second load misses and refills; a reload of 0x40 misses again.
5. Assert rst_b=0 mid-FILL -> mem_req drops asynchronously, stall=0, and a subsequent load of the same address misses (valid cleared).
6. Drop req_valid in the FILL state before mem_ack -> the fill completes, and a later load of that address hits with no mem_req.

Source files
------------

// File: rtl/dcache_mem_stage.sv
// Memory-stage data cache: direct-mapped, one big-endian word per line, write-through.
// Read misses allocate the line; stores go to memory and only update a line they hit.
module dcache_mem_stage #(
   parameter int INDEX_BITS = 5
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            req_valid,
   input  logic            req_write,
   input  logic            is_word,
   input  logic [31:0]     addr,
   input  logic [31:0]     store_data,
   output logic [3:0][7:0] cache_data_out,
   output logic [1:0]      byte_number,
   output logic            stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [31:0]     mem_addr,
   output logic [3:0][7:0] mem_wdata,
   output logic [3:0]      mem_byte_en,
   input  logic [3:0][7:0] mem_rdata,
   input  logic            mem_ack
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [LINES-1:0]      r_valid;
   logic [TAG_BITS-1:0]   r_tag  [LINES];
   logic [3:0][7:0]       r_data [LINES];
   logic [31:0]           r_mem_addr;
   logic [3:0][7:0]       r_mem_wdata;
   logic [3:0]            r_mem_byte_en;

   logic [INDEX_BITS-1:0] w_index;
   logic [INDEX_BITS-1:0] w_fill_index;
   logic [TAG_BITS-1:0]   w_tag;
   logic [TAG_BITS-1:0]   w_fill_tag;
   logic [1:0]            w_lane;
   logic                  w_hit;
   logic                  w_start;
   logic                  w_ack_fill;
   logic                  w_store_hit;
   logic                  w_stall;
   logic [3:0][7:0]       w_data_out;
   logic [3:0][7:0]       w_st_wdata;
   logic [3:0]            w_st_byte_en;

   assign w_index      = addr[INDEX_BITS+1:2];
   assign w_tag        = addr[31:INDEX_BITS+2];
   assign w_fill_index = r_mem_addr[INDEX_BITS+1:2];
   assign w_fill_tag   = r_mem_addr[31:INDEX_BITS+2];
   assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_lane       = 2'd3 - addr[1:0];
   assign w_start      = (r_state == S_IDLE) && req_valid && (req_write || !w_hit);
   assign w_ack_fill   = (r_state == S_FILL) && mem_ack;
   assign w_store_hit  = (r_state == S_IDLE) && req_valid && req_write && w_hit;

   // Store lanes: byte offset k lands on lane 3-k
   always_comb begin
      w_st_wdata   = 32'h0000_0000;
      w_st_byte_en = 4'b0000;
      if (is_word) begin
         w_st_wdata   = store_data;
         w_st_byte_en = 4'b1111;
      end else begin
         w_st_wdata[w_lane]   = store_data[7:0];
         w_st_byte_en[w_lane] = 1'b1;
      end
   end

   // Next state, stall and load data toward WB
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_data_out   = 32'h0000_0000;
      case (r_state)
         S_IDLE: begin
            if (req_valid && req_write) begin
               w_stall      = 1'b1;
               w_next_state = S_WRITE;
            end else if (req_valid && !w_hit) begin
               w_stall      = 1'b1;
               w_next_state = S_FILL;
            end else if (req_valid) begin
               w_data_out   = r_data[w_index];
            end else begin
               w_data_out   = 32'h0000_0000;
            end
         end
         S_FILL: begin
            w_stall = !mem_ack;
            if (mem_ack) begin
               w_data_out   = mem_rdata;
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_FILL;
            end
         end
         S_WRITE: begin
            w_stall = !mem_ack;
            if (mem_ack) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_WRITE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Outputs to WB are forced quiet while reset is asserted, even with a request present
   assign stall          = w_stall && rst_b;
   assign cache_data_out = rst_b ? w_data_out : 32'h0000_0000;
   assign byte_number    = addr[1:0];
   assign mem_req        = (r_state != S_IDLE);
   assign mem_we         = (r_state == S_WRITE);
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign mem_byte_en    = r_mem_byte_en;

   // State register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Memory request fields captured on entry and held until the ack
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_mem_addr    <= 32'h0000_0000;
         r_mem_wdata   <= 32'h0000_0000;
         r_mem_byte_en <= 4'b0000;
      end else if (w_start) begin
         r_mem_addr <= {addr[31:2], 2'b00};
         if (req_write) begin
            r_mem_wdata   <= w_st_wdata;
            r_mem_byte_en <= w_st_byte_en;
         end else begin
            r_mem_wdata   <= 32'h0000_0000;
            r_mem_byte_en <= 4'b1111;
         end
      end else if (mem_req && mem_ack) begin
         r_mem_byte_en <= 4'b0000;
      end
   end

   // Valid bits
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_valid <= {LINES{1'b0}};
      end else if (w_ack_fill) begin
         r_valid[w_fill_index] <= 1'b1;
      end
   end

   // Line data and tags; a fill uses the captured address since the request may have dropped
   always_ff @(posedge clk) begin
      if (w_ack_fill) begin
         r_data[w_fill_index] <= mem_rdata;
         r_tag[w_fill_index]  <= w_fill_tag;
      end else if (w_store_hit) begin
         if (is_word) begin
            r_data[w_index] <= store_data;
         end else begin
            r_data[w_index][w_lane] <= store_data[7:0];
         end
      end
   end
endmodule

// File: tb/tb_dcache_mem_stage.sv
// Bench for dcache_mem_stage: directed plan steps then random traffic against a
// byte-addressed memory model plus a tag/valid presence model of the cache.
module tb_dcache_mem_stage;
   logic            clk = 1'b0;
   logic            rst_b;
   logic            req_valid, req_write, is_word;
   logic [31:0]     addr, store_data;
   logic [3:0][7:0] cache_data_out, mem_wdata, mem_rdata;
   logic [1:0]      byte_number;
   logic            stall, mem_req, mem_we, mem_ack;
   logic [31:0]     mem_addr;
   logic [3:0]      mem_byte_en;

   int errors = 0;
   int checks = 0;
   int ack_delay = 3;

   logic [7:0] env_mem   [logic [31:0]];
   logic [7:0] model_mem [logic [31:0]];
   bit         m_valid [32];
   logic [24:0] m_tag  [32];

   always #5 clk = ~clk;

   dcache_mem_stage #(.INDEX_BITS(5)) dut (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
      .is_word(is_word), .addr(addr), .store_data(store_data),
      .cache_data_out(cache_data_out), .byte_number(byte_number), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic logic [7:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] model_rd(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : init_byte(a);
   endfunction

   // Word as lanes {3,2,1,0}; lane i carries the byte at offset 3-i
   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] base;
      base = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++) w[8*i +: 8] = model_rd(base + 32'(3 - i));
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory responder: acks after ack_delay cycles of mem_req, applies writes by lane
   initial begin
      int cnt;
      cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0000_0000;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
         end else if (mem_req) begin
            cnt++;
            if (cnt >= ack_delay) begin
               for (int i = 0; i < 4; i++)
                  if (mem_we && mem_byte_en[i]) env_mem[mem_addr + 32'(3 - i)] = mem_wdata[i];
               for (int i = 0; i < 4; i++) mem_rdata[i] = env_rd(mem_addr + 32'(3 - i));
               mem_ack = 1'b1;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic access(input bit wr, input bit wd, input logic [31:0] a,
                         input logic [31:0] sd, input string nm);
      logic [31:0] base, exp_wdata, exp_data, data_o, addr_o, wdata_o;
      logic [3:0]  exp_be, be_o;
      logic [1:0]  bn_o;
      int          idx, lane, stalls, n;
      bit          hit, exp_req, done, seen, stable, we_o, timed_out;
      base = {a[31:2], 2'b00};
      idx  = int'(a[6:2]);
      hit  = m_valid[idx] && (m_tag[idx] == a[31:7]);
      exp_req = wr || !hit;
      lane = 3 - int'(a[1:0]);
      exp_wdata = 32'h0000_0000;
      exp_be = 4'b0000;
      if (wd) begin
         exp_wdata = sd;
         exp_be = 4'b1111;
      end else begin
         exp_wdata[8*lane +: 8] = sd[7:0];
         exp_be[lane] = 1'b1;
      end
      if (!wr) exp_be = 4'b1111;
      exp_data = wr ? 32'h0000_0000 : model_word(a);

      req_valid = 1'b1; req_write = wr; is_word = wd; addr = a; store_data = sd;
      stalls = 0; n = 0; done = 1'b0; seen = 1'b0; stable = 1'b1; timed_out = 1'b0;
      data_o = 32'h0; addr_o = 32'h0; wdata_o = 32'h0; be_o = 4'h0; we_o = 1'b0; bn_o = 2'b00;
      while (!done) begin
         @(negedge clk);
         n++;
         if (mem_req) begin
            if (!seen) begin
               addr_o = mem_addr; wdata_o = mem_wdata; be_o = mem_byte_en; we_o = mem_we;
            end else if (addr_o !== mem_addr || wdata_o !== mem_wdata ||
                         be_o !== mem_byte_en || we_o !== mem_we) begin
               stable = 1'b0;
            end
            seen = 1'b1;
         end
         if (!stall) begin
            done = 1'b1;
            data_o = cache_data_out;
            bn_o = byte_number;
         end else begin
            stalls++;
         end
         if (n > 40) begin
            timed_out = 1'b1;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;

      check({nm, "_timeout"}, 32'(timed_out), 32'd0);
      check({nm, "_stall_cycles"}, 32'(stalls), exp_req ? 32'(ack_delay) : 32'd0);
      check({nm, "_data"}, data_o, exp_data);
      check({nm, "_byte_number"}, 32'(bn_o), 32'(a[1:0]));
      check({nm, "_mem_req"}, 32'(seen), 32'(exp_req));
      if (exp_req) begin
         check({nm, "_mem_addr"}, addr_o, base);
         check({nm, "_mem_we"}, 32'(we_o), 32'(wr));
         check({nm, "_byte_en"}, 32'(be_o), 32'(exp_be));
         check({nm, "_held"}, 32'(stable), 32'd1);
         if (wr) check({nm, "_wdata"}, wdata_o, exp_wdata);
      end

      if (wr) begin
         for (int i = 0; i < 4; i++)
            if (exp_be[i]) model_mem[base + 32'(3 - i)] = exp_wdata[8*i +: 8];
      end else if (!hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx] = a[31:7];
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ack_seen;
      logic [31:0] ra;
      rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0; is_word = 1'b0;
      addr = 32'h0; store_data = 32'h0;
      for (int i = 0; i < 32; i++) begin m_valid[i] = 1'b0; m_tag[i] = 25'h0; end
      env_mem[32'h40] = 8'h12; env_mem[32'h41] = 8'h34; env_mem[32'h42] = 8'h56; env_mem[32'h43] = 8'h78;
      model_mem[32'h40] = 8'h12; model_mem[32'h41] = 8'h34; model_mem[32'h42] = 8'h56; model_mem[32'h43] = 8'h78;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_byte_en", 32'(mem_byte_en), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_data", cache_data_out, 32'd0);
      rst_b = 1'b1;
      @(posedge clk);
      #1;

      ack_delay = 3;
      access(1'b0, 1'b1, 32'h0000_0040, 32'h0, "t1_fill");
      access(1'b0, 1'b1, 32'h0000_0040, 32'h0, "t1_hit");
      access(1'b1, 1'b0, 32'h0000_0041, 32'h0000_00AB, "t2_byte_store");
      access(1'b0, 1'b1, 32'h0000_0040, 32'h0, "t2_load");
      access(1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, "t3_word_store");
      access(1'b0, 1'b1, 32'h0000_0080, 32'h0, "t3_load_miss");
      access(1'b0, 1'b1, 32'h0000_0040, 32'h0, "t4_load_40");
      access(1'b0, 1'b1, 32'h0000_00C0, 32'h0, "t4_load_c0");
      access(1'b0, 1'b1, 32'h0000_0040, 32'h0, "t4_reload_40");
      access(1'b0, 1'b1, 32'h0000_0042, 32'h0, "t4_unaligned_word");

      // Reset in the middle of a fill
      ack_delay = 10;
      req_valid = 1'b1; req_write = 1'b0; is_word = 1'b1; addr = 32'h0000_0100; store_data = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5_in_fill", 32'(mem_req), 32'd1);
      #2 rst_b = 1'b0;
      #1;
      check("t5_req_dropped", 32'(mem_req), 32'd0);
      check("t5_stall", 32'(stall), 32'd0);
      check("t5_data", cache_data_out, 32'd0);
      check("t5_byte_en", 32'(mem_byte_en), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      ack_delay = 2;
      access(1'b0, 1'b1, 32'h0000_0100, 32'h0, "t5_after_reset");
      access(1'b0, 1'b1, 32'h0000_0040, 32'h0, "t5_40_invalid");

      // Request withdrawn while the fill is in flight
      ack_delay = 3;
      req_valid = 1'b1; req_write = 1'b0; is_word = 1'b1; addr = 32'h0000_0200;
      @(posedge clk); #1;
      req_valid = 1'b0;
      ack_seen = 1'b0;
      for (int i = 0; i < 20 && !ack_seen; i++) begin
         @(negedge clk);
         if (mem_ack) ack_seen = 1'b1;
      end
      check("t6_ack_seen", 32'(ack_seen), 32'd1);
      @(posedge clk); #1;
      check("t6_idle_after", 32'(mem_req), 32'd0);
      m_valid[0] = 1'b1;
      m_tag[0] = 25'(32'h0000_0200 >> 7);
      access(1'b0, 1'b1, 32'h0000_0200, 32'h0, "t6_hit");

      // Random traffic over a few conflicting tags and indices
      for (int k = 0; k < 150; k++) begin
         int idx_r;
         idx_r = ($urandom_range(0, 4) == 4) ? 16 : int'($urandom_range(0, 3));
         ra = (32'($urandom_range(0, 2)) << 7) | (32'(idx_r) << 2) | 32'($urandom_range(0, 3));
         ack_delay = int'($urandom_range(1, 4));
         access(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ra, $urandom, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
